// File: rtl/bsg_chip_pkg.sv
// Shared types for the IO MMIO responder: processor configs, bedrock memory messages,
// address map offsets, FSM states and access error codes.
package bsg_chip_pkg;

    typedef enum logic [1:0] {
        e_bp_single_core_cfg,
        e_bp_dual_core_cfg,
        e_bp_quad_core_cfg
    } bp_params_e;

    localparam bp_params_e bp_cfg_gp = e_bp_dual_core_cfg;

    typedef struct packed {
        int unsigned paddr_width;
        int unsigned cce_block_width;
        int unsigned lce_id_width;
        int unsigned lce_assoc;
        int unsigned num_core;
    } bp_proc_param_s;

    // Configs differ only in core count; the message layout below is shared by all of them.
    function automatic bp_proc_param_s bp_proc_param(bp_params_e cfg);
        bp_proc_param_s p;
        p.paddr_width     = 40;
        p.cce_block_width = 512;
        p.lce_id_width    = 4;
        p.lce_assoc       = 8;
        case (cfg)
            e_bp_single_core_cfg: p.num_core = 1;
            e_bp_quad_core_cfg:   p.num_core = 4;
            default:              p.num_core = 2;
        endcase
        return p;
    endfunction

    localparam int paddr_width_gp    = 40;
    localparam int lce_id_width_gp   = 4;
    localparam int mem_data_width_gp = 64;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1 = 3'd0,
        e_bedrock_msg_size_2 = 3'd1,
        e_bedrock_msg_size_4 = 3'd2,
        e_bedrock_msg_size_8 = 3'd3
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_gp-1:0] lce_id;
        bp_bedrock_msg_size_e       size;
        logic [paddr_width_gp-1:0]  addr;
        bp_bedrock_mem_type_e       msg_type;
    } bp_bedrock_mem_header_s;

    typedef struct packed {
        bp_bedrock_mem_header_s         header;
        logic [mem_data_width_gp-1:0]   data;
    } bp_bedrock_mem_msg_s;

    localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_mem_msg_s);

    localparam logic [19:0] putchar_addr_gp = 20'h01000;
    localparam logic [19:0] finish_base_gp  = 20'h02000;
    localparam logic [19:0] scratch_base_gp = 20'h03000;

    typedef enum logic [1:0] {
        e_idle,
        e_stall,
        e_resp
    } mmio_state_e;

    typedef enum logic [1:0] {
        e_mmio_ok,
        e_mmio_unmapped,
        e_mmio_misaligned,
        e_mmio_write_only
    } mmio_err_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO, one write port and one read port.
// Latency: a push is visible on data_o the cycle after it is written.
// Backpressure: ready_o drops when full; a push while full is legal only with a same-cycle pop.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [ptr_w_lp:0]   count_r;

    assign ready_o = (count_r != (ptr_w_lp+1)'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rd_ptr_r];

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (v_i)    wr_ptr_r <= wr_ptr_r + 1'b1;
            if (yumi_i) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({v_i, yumi_i})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i) mem_r[wr_ptr_r] <= data_i;
    end

    a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
    a_no_overflow:  assert property (@(posedge clk_i) disable iff (reset_i) v_i |-> (ready_o || yumi_i));

endmodule

// File: rtl/bsg_io_mmio_responder.sv
// MMIO responder: putchar buffer, per-core finish flags, and byte-maskable scratch registers.
// Latency: response valid 1 cycle after acceptance; a putchar into a full buffer waits in STALL.
// Backpressure: accepts only in IDLE; holds the response until io_resp_yumi_i.
module bsg_io_mmio_responder
    import bsg_chip_pkg::*;
#(
    parameter bp_params_e bp_params_p     = bp_cfg_gp,
    parameter int         char_fifo_els_p = 4,
    parameter int         scratch_els_p   = 8,
    localparam bp_proc_param_s proc_param_lp = bp_proc_param(bp_params_p),
    localparam int             num_core_p    = int'(proc_param_lp.num_core)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_gp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_ready_o,

    output logic [cce_mem_msg_width_gp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_yumi_i,

    output logic [7:0]                      char_o,
    output logic                            char_v_o,
    input  logic                            char_yumi_i,

    output logic [num_core_p-1:0]           finish_o,
    output logic                            all_finish_o,
    output logic                            fail_o,
    output logic                            err_o
);
    bp_bedrock_mem_msg_s cmd, resp_r;
    mmio_state_e         state_r, state_n;
    mmio_err_e           err_code;

    logic [63:0]           scratch_r [scratch_els_p];
    logic [num_core_p-1:0] finish_r;
    logic                  fail_r;
    logic [7:0]            pending_char_r;

    logic [19:0] addr_lo;
    logic [8:0]  slot;
    logic        is_read, is_write, size_ok, aligned;
    logic [2:0]  low_mask;
    logic [7:0]  byte_mask_base, byte_mask;
    logic [63:0] wdata, scratch_rd;
    logic        hit_putchar, hit_finish, hit_scratch;
    logic        accept, mapped_ok, putchar_wr, scratch_wr, finish_wr;
    logic        char_ready, push_space, char_push;
    logic [7:0]  char_push_dat;

    assign cmd     = io_cmd_i;
    assign addr_lo = cmd.header.addr[19:0];
    assign slot    = addr_lo[11:3];

    always_comb begin
        is_read        = 1'b0;
        is_write       = 1'b0;
        size_ok        = 1'b1;
        low_mask       = 3'b000;
        byte_mask_base = 8'h00;
        case (cmd.header.msg_type)
            e_bedrock_mem_rd, e_bedrock_mem_uc_rd: is_read  = 1'b1;
            e_bedrock_mem_wr, e_bedrock_mem_uc_wr: is_write = 1'b1;
            default: ;
        endcase
        case (cmd.header.size)
            e_bedrock_msg_size_1: begin low_mask = 3'b000; byte_mask_base = 8'h01; end
            e_bedrock_msg_size_2: begin low_mask = 3'b001; byte_mask_base = 8'h03; end
            e_bedrock_msg_size_4: begin low_mask = 3'b011; byte_mask_base = 8'h0F; end
            e_bedrock_msg_size_8: begin low_mask = 3'b111; byte_mask_base = 8'hFF; end
            default:              size_ok = 1'b0;
        endcase
    end

    assign aligned   = size_ok && ((addr_lo[2:0] & low_mask) == 3'b000);
    assign byte_mask = byte_mask_base << addr_lo[2:0];
    assign wdata     = cmd.data << {addr_lo[2:0], 3'b000};

    // Finish and putchar are whole-word registers; any sub-word offset into them is unmapped.
    assign hit_putchar = (addr_lo == putchar_addr_gp);
    assign hit_finish  = (addr_lo[19:12] == finish_base_gp[19:12]) && (addr_lo[2:0] == 3'b000)
                         && (int'(slot) < num_core_p);
    assign hit_scratch = (addr_lo[19:12] == scratch_base_gp[19:12]) && (int'(slot) < scratch_els_p);

    always_comb begin
        err_code = e_mmio_ok;
        if (!(is_read || is_write))          err_code = e_mmio_unmapped;
        else if (!aligned)                   err_code = e_mmio_misaligned;
        else if (hit_putchar || hit_finish)  err_code = is_read ? e_mmio_write_only : e_mmio_ok;
        else if (!hit_scratch)               err_code = e_mmio_unmapped;
    end

    always_comb begin
        scratch_rd = '0;
        for (int i = 0; i < scratch_els_p; i++) begin
            if (int'(slot) == i) scratch_rd = scratch_r[i];
        end
    end

    assign io_cmd_ready_o = (state_r == e_idle) && !reset_i;
    assign accept         = io_cmd_v_i && io_cmd_ready_o;
    assign mapped_ok      = accept && (err_code == e_mmio_ok);
    assign putchar_wr     = mapped_ok && hit_putchar;
    assign scratch_wr     = mapped_ok && hit_scratch && is_write;
    assign finish_wr      = mapped_ok && hit_finish;
    assign err_o          = accept && (err_code != e_mmio_ok);
    assign push_space     = char_ready || char_yumi_i;

    always_comb begin
        state_n       = state_r;
        char_push     = 1'b0;
        char_push_dat = cmd.data[7:0];
        case (state_r)
            e_idle: begin
                if (accept) begin
                    if (putchar_wr && !push_space) begin
                        state_n = e_stall;
                    end else begin
                        state_n   = e_resp;
                        char_push = putchar_wr;
                    end
                end
            end
            e_stall: begin
                char_push_dat = pending_char_r;
                if (push_space) begin
                    state_n   = e_resp;
                    char_push = 1'b1;
                end
            end
            e_resp: begin
                if (io_resp_yumi_i) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_r         <= '0;
            pending_char_r <= '0;
            finish_r       <= '0;
            fail_r         <= 1'b0;
            for (int i = 0; i < scratch_els_p; i++) scratch_r[i] <= '0;
        end else begin
            if (accept) begin
                resp_r.header  <= cmd.header;
                resp_r.data    <= (mapped_ok && hit_scratch && is_read) ? scratch_rd : '0;
                pending_char_r <= cmd.data[7:0];
            end
            if (scratch_wr) begin
                for (int i = 0; i < scratch_els_p; i++) begin
                    for (int b = 0; b < 8; b++) begin
                        if (int'(slot) == i && byte_mask[b]) scratch_r[i][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (finish_wr) begin
                for (int c = 0; c < num_core_p; c++) begin
                    if (int'(slot) == c) finish_r[c] <= 1'b1;
                end
                if (cmd.data[0]) fail_r <= 1'b1;
            end
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (8),
        .els_p   (char_fifo_els_p)
    ) char_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (char_push),
        .data_i  (char_push_dat),
        .ready_o (char_ready),
        .v_o     (char_v_o),
        .data_o  (char_o),
        .yumi_i  (char_yumi_i)
    );

    assign io_resp_o    = resp_r;
    assign io_resp_v_o  = (state_r == e_resp);
    assign finish_o     = finish_r;
    assign all_finish_o = &finish_r;
    assign fail_o       = fail_r;

    a_cmd_ready_then_valid: assert property (@(posedge clk_i) disable iff (reset_i) io_cmd_v_i |-> io_cmd_ready_o);
    a_yumi_when_valid:      assert property (@(posedge clk_i) disable iff (reset_i) io_resp_yumi_i |-> io_resp_v_o);

endmodule

// File: tb/tb_bsg_io_mmio_responder.sv
// Directed bench for bsg_io_mmio_responder: vector table of single transactions plus
// hand sequences for putchar stall, finish/fail flags and mid-transaction reset.
module tb_bsg_io_mmio_responder;
    import bsg_chip_pkg::*;

    localparam logic [3:0] RD = 4'd0, WR = 4'd1, URD = 4'd2, UWR = 4'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [cce_mem_msg_width_gp-1:0] io_cmd, io_resp;
    logic        io_cmd_v, io_cmd_ready, io_resp_v, io_resp_yumi;
    logic [7:0]  char_dat;
    logic        char_v, char_yumi;
    logic [1:0]  finish;
    logic        all_finish, fail, err;

    int total = 0;
    int bad   = 0;
    int tag   = 0;
    logic err_at_accept;
    logic issued;

    always #5 clk = ~clk;

    bsg_io_mmio_responder dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .io_cmd_i       (io_cmd),
        .io_cmd_v_i     (io_cmd_v),
        .io_cmd_ready_o (io_cmd_ready),
        .io_resp_o      (io_resp),
        .io_resp_v_o    (io_resp_v),
        .io_resp_yumi_i (io_resp_yumi),
        .char_o         (char_dat),
        .char_v_o       (char_v),
        .char_yumi_i    (char_yumi),
        .finish_o       (finish),
        .all_finish_o   (all_finish),
        .fail_o         (fail),
        .err_o          (err)
    );

    typedef struct {
        logic [3:0]  mt;
        logic [2:0]  sz;
        logic [19:0] addr;
        logic [63:0] data;
        logic        exp_err;
        logic [63:0] exp_dat;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mkv(logic [3:0] mt, logic [2:0] sz, logic [19:0] a,
                                 logic [63:0] d, logic e, logic [63:0] x);
        vec_t v;
        v.mt = mt; v.sz = sz; v.addr = a; v.data = d; v.exp_err = e; v.exp_dat = x;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic bp_bedrock_mem_msg_s mkmsg(logic [3:0] mt, logic [2:0] sz, logic [19:0] a,
                                                  logic [63:0] d);
        bp_bedrock_mem_msg_s m;
        m.header.lce_id   = 4'(tag);
        m.header.size     = bp_bedrock_msg_size_e'(sz);
        m.header.addr     = {20'h0, a};
        m.header.msg_type = bp_bedrock_mem_type_e'(mt);
        m.data            = d;
        return m;
    endfunction

    // Called at a negedge; returns at posedge+1 with the command withdrawn.
    task automatic issue(input bp_bedrock_mem_msg_s m);
        int n = 0;
        while (!io_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        issued = io_cmd_ready;
        if (!issued) begin
            chk("cmd_ready_timeout", 64'(io_cmd_ready), 64'd1);
            err_at_accept = 1'b0;
        end else begin
            io_cmd   = m;
            io_cmd_v = 1'b1;
            #1;
            err_at_accept = err;
            @(posedge clk);
            #1;
            io_cmd_v = 1'b0;
        end
    endtask

    task automatic take_resp();
        io_resp_yumi = 1'b1;
        @(posedge clk);
        #1;
        io_resp_yumi = 1'b0;
        @(negedge clk);
    endtask

    task automatic txn(input string nm, input logic [3:0] mt, input logic [2:0] sz, input logic [19:0] a,
                       input logic [63:0] d, input logic exp_err, input logic [63:0] exp_dat);
        bp_bedrock_mem_msg_s m, r;
        tag++;
        m = mkmsg(mt, sz, a, d);
        issue(m);
        if (issued) begin
            chk({nm, "_err"}, 64'(err_at_accept), 64'(exp_err));
            @(negedge clk);
            chk({nm, "_err_pulse"}, 64'(err), 64'd0);
            chk({nm, "_resp_v"}, 64'(io_resp_v), 64'd1);
            r = io_resp;
            chk({nm, "_data"}, r.data, exp_dat);
            chk({nm, "_hdr"}, 64'(r.header), 64'(m.header));
            if (io_resp_v) take_resp();
        end
    endtask

    task automatic pop_char(input string nm, input logic [7:0] exp);
        chk({nm, "_v"}, 64'(char_v), 64'd1);
        chk({nm, "_dat"}, 64'(char_dat), 64'(exp));
        if (char_v) begin
            char_yumi = 1'b1;
            @(posedge clk);
            #1;
            char_yumi = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        bp_bedrock_mem_msg_s m, r;

        vecs[0]  = mkv(WR,  3, 20'h03008, 64'hDEADBEEF_CAFEF00D, 0, 64'h0);
        vecs[1]  = mkv(WR,  1, 20'h0300A, 64'h0000_1234,         0, 64'h0);
        vecs[2]  = mkv(URD, 3, 20'h03008, 64'h0,                 0, 64'hDEADBEEF_1234F00D);
        vecs[3]  = mkv(UWR, 0, 20'h03001, 64'hAB,                0, 64'h0);
        vecs[4]  = mkv(WR,  2, 20'h03004, 64'h11223344,          0, 64'h0);
        vecs[5]  = mkv(RD,  3, 20'h03000, 64'h0,                 0, 64'h11223344_0000AB00);
        vecs[6]  = mkv(WR,  1, 20'h03001, 64'hFFFF,              1, 64'h0);
        vecs[7]  = mkv(RD,  3, 20'h03000, 64'h0,                 0, 64'h11223344_0000AB00);
        vecs[8]  = mkv(RD,  3, 20'h01000, 64'h0,                 1, 64'h0);
        vecs[9]  = mkv(WR,  3, 20'h05000, 64'h5,                 1, 64'h0);
        vecs[10] = mkv(WR,  3, 20'h03040, 64'hFFFF_FFFF,         1, 64'h0);
        vecs[11] = mkv(RD,  3, 20'h03038, 64'h0,                 0, 64'h0);
        vecs[12] = mkv(RD,  3, 20'h02000, 64'h0,                 1, 64'h0);
        vecs[13] = mkv(WR,  3, 20'h02010, 64'h1,                 1, 64'h0);
        vecs[14] = mkv(RD,  2, 20'h0300C, 64'h0,                 0, 64'hDEADBEEF_1234F00D);
        vecs[15] = mkv(WR,  4, 20'h03008, 64'h0,                 1, 64'h0);
        vecs[16] = mkv(RD,  3, 20'h03008, 64'h0,                 0, 64'hDEADBEEF_1234F00D);
        vecs[17] = mkv(WR,  0, 20'h0300F, 64'hFFFF_FFFF_FFFF_FF77, 0, 64'h0);
        vecs[18] = mkv(RD,  3, 20'h03008, 64'h0,                 0, 64'h77ADBEEF_1234F00D);
        vecs[19] = mkv(4'hF, 3, 20'h03000, 64'h0,                1, 64'h0);
        vecs[20] = mkv(RD,  3, 20'h03004, 64'h0,                 1, 64'h0);

        rst = 1'b1; io_cmd = '0; io_cmd_v = 1'b0; io_resp_yumi = 1'b0; char_yumi = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",      64'(io_cmd_ready), 64'd0);
        chk("rst_resp_v",     64'(io_resp_v),    64'd0);
        chk("rst_char_v",     64'(char_v),       64'd0);
        chk("rst_finish",     64'(finish),       64'd0);
        chk("rst_all_finish", 64'(all_finish),   64'd0);
        chk("rst_fail",       64'(fail),         64'd0);
        chk("rst_err",        64'(err),          64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(io_cmd_ready), 64'd1);

        for (int i = 0; i < 21; i++) begin
            txn($sformatf("v%0d", i), vecs[i].mt, vecs[i].sz, vecs[i].addr, vecs[i].data,
                vecs[i].exp_err, vecs[i].exp_dat);
        end
        chk("err_no_finish", 64'(finish), 64'd0);
        chk("err_no_fail",   64'(fail),   64'd0);
        chk("err_no_char",   64'(char_v), 64'd0);

        // single putchar
        txn("putc41", WR, 0, 20'h01000, 64'h41, 0, 64'h0);
        pop_char("putc41_char", 8'h41);
        chk("putc41_empty", 64'(char_v), 64'd0);

        // fill the buffer, then stall on the fifth
        for (int k = 0; k < 4; k++) txn($sformatf("fill%0d", k), WR, 0, 20'h01000, 64'(8'h61 + k), 0, 64'h0);
        tag++;
        m = mkmsg(WR, 0, 20'h01000, 64'h65);
        issue(m);
        chk("stall_err", 64'(err_at_accept), 64'd0);
        @(negedge clk);
        chk("stall_resp_v0", 64'(io_resp_v),    64'd0);
        chk("stall_ready0",  64'(io_cmd_ready), 64'd0);
        @(negedge clk);
        chk("stall_resp_v1", 64'(io_resp_v),    64'd0);
        pop_char("stall_pop", 8'h61);
        chk("stall_release", 64'(io_resp_v), 64'd1);
        r = io_resp;
        chk("stall_data", r.data, 64'h0);
        chk("stall_hdr",  64'(r.header), 64'(m.header));
        if (io_resp_v) take_resp();
        for (int k = 0; k < 4; k++) pop_char($sformatf("drain%0d", k), 8'h62 + 8'(k));
        chk("drain_empty", 64'(char_v), 64'd0);

        // finish flags and sticky fail
        txn("fin0", WR, 3, 20'h02000, 64'h0, 0, 64'h0);
        chk("fin0_flags", 64'(finish),     64'h1);
        chk("fin0_all",   64'(all_finish), 64'd0);
        txn("fin1", WR, 3, 20'h02008, 64'h0, 0, 64'h0);
        chk("fin1_flags", 64'(finish),     64'h3);
        chk("fin1_all",   64'(all_finish), 64'd1);
        chk("fin1_fail",  64'(fail),       64'd0);
        txn("finf", WR, 3, 20'h02000, 64'h1, 0, 64'h0);
        chk("finf_fail",  64'(fail),       64'd1);
        chk("finf_flags", 64'(finish),     64'h3);

        // reset while a response is pending
        txn("pre_rst_putc", WR, 0, 20'h01000, 64'h7A, 0, 64'h0);
        txn("pre_rst_wr",   WR, 3, 20'h03010, 64'h55, 0, 64'h0);
        tag++;
        m = mkmsg(RD, 3, 20'h03010, 64'h0);
        issue(m);
        @(negedge clk);
        chk("pend_resp_v", 64'(io_resp_v), 64'd1);
        r = io_resp;
        chk("pend_data", r.data, 64'h55);
        rst = 1'b1;
        #1;
        chk("midrst_resp_v", 64'(io_resp_v),    64'd0);
        chk("midrst_char_v", 64'(char_v),       64'd0);
        chk("midrst_ready",  64'(io_cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready",  64'(io_cmd_ready), 64'd1);
        chk("after_rst_resp_v", 64'(io_resp_v),    64'd0);
        chk("after_rst_finish", 64'(finish),       64'd0);
        chk("after_rst_fail",   64'(fail),         64'd0);
        txn("after_rst_rd", RD, 3, 20'h03010, 64'h0, 0, 64'h0);
        txn("after_rst_putc", WR, 0, 20'h01000, 64'h42, 0, 64'h0);
        pop_char("after_rst_char", 8'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
